car_controller: RTL and testbench

//  Per-car elevator controller. It receives floor calls granted to this car by the

---
 rtl/rideup_pkg.sv | 38 +++
 rtl/call_register.sv | 59 +++++
 rtl/car_controller.sv | 145 ++++++++++++++
 tb/tb_car_controller.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rideup_pkg.sv
// Shared types and helpers for the per-car elevator controller.
// Floor numbers are FLOOR_W bits wide; call bitmaps are widened to MAX_FLOORS for the helpers.
package rideup_pkg;

  localparam int FLOOR_W    = 4;
  localparam int MAX_FLOORS = 1 << FLOOR_W;

  localparam logic [1:0] DIR_UP   = 2'b11;
  localparam logic [1:0] DIR_DN   = 2'b01;
  localparam logic [1:0] DIR_IDLE = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE,
    ST_DOOR
  } car_state_e;

  function automatic logic any_above(input logic [MAX_FLOORS-1:0] pend,
                                     input logic [FLOOR_W-1:0]    flr);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (i > int'(flr)) hit = hit | pend[i];
    end
    return hit;
  endfunction

  function automatic logic any_below(input logic [MAX_FLOORS-1:0] pend,
                                     input logic [FLOOR_W-1:0]    flr);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (i < int'(flr)) hit = hit | pend[i];
    end
    return hit;
  endfunction

endpackage

// File: rtl/call_register.sv
// Outstanding-call bitmap for one car: set/clear arbitration and above/below flags.
// With CAB_CALL_EN defined, in-car buttons are OR-ed into the bitmap every cycle.
module call_register
  import rideup_pkg::*;
#(
  parameter int NFLOORS = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  set_valid,
  input  logic [FLOOR_W-1:0]    set_floor,
`ifdef CAB_CALL_EN
  input  logic [NFLOORS-1:0]    cab_call,
`endif
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  hold,
  input  logic                  clr_valid,
  input  logic [FLOOR_W-1:0]    clr_floor,
  output logic [NFLOORS-1:0]    pending,
  output logic [MAX_FLOORS-1:0] req,
  output logic                  here_call,
  output logic                  above,
  output logic                  below
);

  localparam logic [MAX_FLOORS-1:0] VALID_MASK =
    MAX_FLOORS'((64'd1 << NFLOORS) - 64'd1);

  logic [MAX_FLOORS-1:0] set_vec;
  logic [MAX_FLOORS-1:0] clr_vec;
  logic [MAX_FLOORS-1:0] here_mask;
  logic [MAX_FLOORS-1:0] pending_next;

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    set_vec   = '0;
    here_mask = MAX_FLOORS'(1) << cur_floor;
    if (set_valid && (32'(set_floor) < NFLOORS)) set_vec[set_floor] = 1'b1;
`ifdef CAB_CALL_EN
    set_vec = set_vec | (MAX_FLOORS'(cab_call) & VALID_MASK);
`endif
    here_call = |(set_vec & here_mask);
    // A stopped car serves its own floor by opening the door, not by latching a call.
    if (hold) set_vec = set_vec & ~here_mask;

    clr_vec = clr_valid ? (MAX_FLOORS'(1) << clr_floor) : '0;

    req          = MAX_FLOORS'(pending) | set_vec;
    pending_next = req & ~clr_vec;
    above        = any_above(req, cur_floor);
    below        = any_below(req, cur_floor);
  end

  always_ff @(posedge clock) begin
    if (reset) pending <= '0;
    else       pending <= pending_next[NFLOORS-1:0];
  end

endmodule

// File: rtl/car_controller.sv
// Per-car controller: collective up/down sweep, floor stepping and door timer.
// Optional CAB_CALL_EN adds the cab_call in-car button input.
module car_controller
  import rideup_pkg::*;
#(
  parameter int NFLOORS       = 16,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               grant,
  input  logic [FLOOR_W-1:0] obj,
`ifdef CAB_CALL_EN
  input  logic [NFLOORS-1:0] cab_call,
`endif
  output logic [5:0]         state,
  output logic               door_open,
  output logic               arrived,
  output logic [NFLOORS-1:0] pending
);

  localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);

  car_state_e            fsm;
  logic [TW-1:0]         timer;
  logic [FLOOR_W-1:0]    floor;
  logic [1:0]            dir;

  logic [MAX_FLOORS-1:0] req;
  logic                  here_call;
  logic                  above;
  logic                  below;
  logic                  hold;
  logic                  step_blocked;
  logic [FLOOR_W-1:0]    next_floor;
  logic                  clr_valid;
  logic [FLOOR_W-1:0]    clr_floor;
  logic [1:0]            resume_dir;

  assign state = {floor, dir};
  assign hold  = (fsm != ST_MOVE);

  call_register #(.NFLOORS(NFLOORS)) u_calls (
    .clock     (clock),
    .reset     (reset),
    .set_valid (grant),
    .set_floor (obj),
`ifdef CAB_CALL_EN
    .cab_call  (cab_call),
`endif
    .cur_floor (floor),
    .hold      (hold),
    .clr_valid (clr_valid),
    .clr_floor (clr_floor),
    .pending   (pending),
    .req       (req),
    .here_call (here_call),
    .above     (above),
    .below     (below)
  );

  always_comb begin
    next_floor   = (dir == DIR_UP) ? floor + 1'b1 : floor - 1'b1;
    step_blocked = (dir == DIR_UP) ? (floor == FLOOR_W'(NFLOORS - 1)) : (floor == '0);
    // A step that would leave the shaft is suppressed and treated as a stop here.
    clr_valid    = (fsm == ST_MOVE) && (timer == '0) && (step_blocked || req[next_floor]);
    clr_floor    = step_blocked ? floor : next_floor;

    // Keep sweeping the current way if possible; idle cars and ties favour up.
    resume_dir = DIR_IDLE;
    if (dir == DIR_DN) begin
      if (below)      resume_dir = DIR_DN;
      else if (above) resume_dir = DIR_UP;
    end else begin
      if (above)      resume_dir = DIR_UP;
      else if (below) resume_dir = DIR_DN;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm       <= ST_IDLE;
      timer     <= '0;
      floor     <= '0;
      dir       <= DIR_IDLE;
      door_open <= 1'b0;
      arrived   <= 1'b0;
    end else begin
      arrived <= 1'b0;
      unique case (fsm)
        ST_IDLE: begin
          if (here_call) begin
            fsm       <= ST_DOOR;
            door_open <= 1'b1;
            arrived   <= 1'b1;
            timer     <= DOOR_LOAD;
          end else if (resume_dir != DIR_IDLE) begin
            fsm   <= ST_MOVE;
            dir   <= resume_dir;
            timer <= TRAVEL_LOAD;
          end
        end
        ST_MOVE: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            if (!step_blocked) floor <= next_floor;
            if (clr_valid) begin
              fsm       <= ST_DOOR;
              door_open <= 1'b1;
              arrived   <= 1'b1;
              timer     <= DOOR_LOAD;
            end else begin
              timer <= TRAVEL_LOAD;
            end
          end
        end
        ST_DOOR: begin
          if (here_call) begin
            timer <= DOOR_LOAD;
          end else if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            door_open <= 1'b0;
            dir       <= resume_dir;
            if (resume_dir == DIR_IDLE) begin
              fsm   <= ST_IDLE;
              timer <= '0;
            end else begin
              fsm   <= ST_MOVE;
              timer <= TRAVEL_LOAD;
            end
          end
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_car_controller.sv
// Scoreboard bench for car_controller: stimulus queues expected arrivals, a monitor checks them.
// A second 10-floor instance covers dropping of out-of-range floor requests.
module tb_car_controller;

  localparam int DOOR_CYCLES = 4;

  typedef struct {
    logic [5:0]  st;
    logic [15:0] pend;
    string       tag;
  } arrival_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        grant = 1'b0;
  logic [3:0]  obj   = '0;
  logic [5:0]  state;
  logic        door_open;
  logic        arrived;
  logic [15:0] pending;

  logic        grant10 = 1'b0;
  logic [3:0]  obj10   = '0;
  logic [5:0]  state10;
  logic        door10;
  logic        arrived10;
  logic [9:0]  pending10;

`ifdef CAB_CALL_EN
  logic [15:0] cab_call   = '0;
  logic [9:0]  cab_call10 = '0;
`endif

  int errors = 0;
  int checks = 0;
  arrival_t sb[$];

  always #5 clock = ~clock;

  car_controller #(.NFLOORS(16), .TRAVEL_CYCLES(8), .DOOR_CYCLES(DOOR_CYCLES)) dut (
    .clock     (clock),
    .reset     (reset),
    .grant     (grant),
    .obj       (obj),
`ifdef CAB_CALL_EN
    .cab_call  (cab_call),
`endif
    .state     (state),
    .door_open (door_open),
    .arrived   (arrived),
    .pending   (pending)
  );

  car_controller #(.NFLOORS(10), .TRAVEL_CYCLES(8), .DOOR_CYCLES(DOOR_CYCLES)) dut10 (
    .clock     (clock),
    .reset     (reset),
    .grant     (grant10),
    .obj       (obj10),
`ifdef CAB_CALL_EN
    .cab_call  (cab_call10),
`endif
    .state     (state10),
    .door_open (door10),
    .arrived   (arrived10),
    .pending   (pending10)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_arrival(input logic [5:0] st, input logic [15:0] p, input string tag);
    arrival_t e;
    e.st   = st;
    e.pend = p;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic issue(input logic [3:0] f);
    @(negedge clock);
    grant = 1'b1;
    obj   = f;
    @(negedge clock);
    grant = 1'b0;
    obj   = '0;
  endtask

  task automatic issue10(input logic [3:0] f);
    @(negedge clock);
    grant10 = 1'b1;
    obj10   = f;
    @(negedge clock);
    grant10 = 1'b0;
    obj10   = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_floor(input logic [3:0] f, input string name);
    int n;
    n = 0;
    while (state[5:2] !== f && n < 300) begin
      @(negedge clock);
      n++;
    end
    check(name, 32'(state[5:2]), 32'(f));
  endtask

  task automatic wait_idle(input logic [5:0] exp_state, input string name);
    int n;
    n = 0;
    while (!(door_open === 1'b0 && state[1:0] === 2'b00) && n < 400) begin
      @(negedge clock);
      n++;
    end
    check(name, 32'(state), 32'(exp_state));
  endtask

  // Monitor: every arrival pulse is matched against the oldest expected stop.
  initial begin
    arrival_t e;
    int door_cnt;
    door_cnt = 0;
    forever begin
      @(negedge clock);
      if (arrived === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_arrival", 32'(arrived), 32'd0);
        end else begin
          e = sb.pop_front();
          check({e.tag, "_state"},   32'(state),     32'(e.st));
          check({e.tag, "_pending"}, 32'(pending),   32'(e.pend));
          check({e.tag, "_door"},    32'(door_open), 32'd1);
        end
      end
      if (door_open === 1'b1) begin
        door_cnt++;
      end else if (door_cnt != 0) begin
        check("door_cycles", 32'(door_cnt), 32'(DOOR_CYCLES));
        door_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tick(2);
    reset = 1'b0;
    check("reset_state",     32'(state),     32'h0);
    check("reset_pending",   32'(pending),   32'h0);
    check("reset_door",      32'(door_open), 32'h0);
    check("reset_arrived",   32'(arrived),   32'h0);
    check("reset_state10",   32'(state10),   32'h0);
    check("reset_pending10", 32'(pending10), 32'h0);

    // Same-floor call while idle at 0: door cycles, nothing latched.
    expect_arrival(6'b0000_00, 16'h0000, "t2_arrive0");
    issue(4'd0);
    check("t2_door_now", 32'(door_open), 32'd1);
    check("t2_pending",  32'(pending),   32'h0);
    wait_idle(6'b0000_00, "t2_idle");

    // Single call to 3: direction next cycle, exact first-step timing.
    expect_arrival(6'b0011_11, 16'h0000, "t1_arrive3");
    issue(4'd3);
    check("t1_dir_up",  32'(state[1:0]), 32'h3);
    check("t1_pending", 32'(pending),    32'h0008);
    tick(7);
    check("t1_floor0_hold", 32'(state[5:2]), 32'd0);
    tick(1);
    check("t1_floor1", 32'(state[5:2]), 32'd1);
    wait_idle(6'b0011_00, "t1_idle");
    check("t1_pending_end", 32'(pending), 32'h0);

    // Intermediate call picked up on the way up.
    do_reset();
    expect_arrival(6'b0101_11, 16'h0080, "t3_arrive5");
    expect_arrival(6'b0111_11, 16'h0000, "t3_arrive7");
    issue(4'd7);
    wait_floor(4'd3, "t3_at3");
    issue(4'd5);
    wait_idle(6'b0111_00, "t3_idle");

    // Call for the floor reached on the very same edge: served, never latched.
    expect_arrival(6'b1001_11, 16'h0400, "te_arrive9");
    expect_arrival(6'b1010_11, 16'h0000, "te_arrive10");
    issue(4'd10);
    wait_floor(4'd8, "te_at8");
    tick(6);
    issue(4'd9);
    check("te_pending", 32'(pending), 32'h0400);
    wait_idle(6'b1010_00, "te_idle");

    // Call behind the sweep: reversal after the far stop.
    do_reset();
    expect_arrival(6'b1001_11, 16'h0004, "t4_arrive9");
    expect_arrival(6'b0010_01, 16'h0000, "t4_arrive2");
    issue(4'd9);
    wait_floor(4'd5, "t4_at5");
    issue(4'd2);
    wait_idle(6'b0010_00, "t4_idle");

    // Reset mid-travel clears everything, no arrival afterwards.
    issue(4'd12);
    wait_floor(4'd6, "t5_at6");
    tick(3);
    check("t5_pending_pre", 32'(pending), 32'h1000);
    do_reset();
    check("t5_state",   32'(state),     32'h0);
    check("t5_pending", 32'(pending),   32'h0);
    check("t5_door",    32'(door_open), 32'h0);
    check("t5_arrived", 32'(arrived),   32'h0);
    tick(20);
    check("t5_stays_idle", 32'(state), 32'h0);

    // Out-of-range floors dropped on the 10-floor car.
    issue10(4'd15);
    check("t6_pending15", 32'(pending10), 32'h0);
    check("t6_state15",   32'(state10),   32'h0);
    issue10(4'd10);
    check("t6_pending10", 32'(pending10), 32'h0);
    tick(5);
    check("t6_state_idle", 32'(state10), 32'h0);
    check("t6_door_idle",  32'(door10),  32'h0);

    tick(2);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
